// File: rtl/matrix_stream_transpose.sv
// matrix_stream_transpose: ping-pong NxN streaming transposer (define MATRIX_TRANSPOSE_BYPASS_EN for per-matrix row-major bypass)
module matrix_stream_transpose #(
    parameter int DW = 3,
    parameter int N  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
    input  logic          bypass,
`endif
    output logic          out_last
);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int CW = $clog2(N);
    logic [DW-1:0] mem [2][NN];
    logic [1:0]    full;
    logic          wr_sel, rd_sel;
    logic [IW-1:0] wr_idx, rd_addr;
    logic [CW-1:0] rd_row, rd_col;
    logic          in_fire, out_fire, wr_end, row_end, col_end, rd_end, col_first;
    assign in_ready  = !full[wr_sel];
    assign in_fire   = in_valid && in_ready;
    assign out_valid = full[rd_sel];
    assign out_fire  = out_valid && out_ready;
    assign wr_end    = wr_idx == IW'(NN - 1);
    assign row_end   = rd_row == CW'(N - 1);
    assign col_end   = rd_col == CW'(N - 1);
    assign rd_end    = row_end && col_end;
    assign out_last  = out_valid && rd_end;
    assign rd_addr   = IW'(rd_row) * IW'(N) + IW'(rd_col);
    assign out_data  = mem[rd_sel][rd_addr];
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
    logic [1:0] byp;
    assign col_first = byp[rd_sel];
`else
    assign col_first = 1'b0;
`endif
    // element storage; contents survive reset since full flags gate visibility
    always_ff @(posedge clk)
        if (in_fire) mem[wr_sel][wr_idx] <= in_data;
    // write/read pointers and per-bank full flags; a bank's set and clear never coincide
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_idx <= '0;
            rd_row <= '0;
            rd_col <= '0;
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
            byp    <= '0;
`endif
        end else begin
            if (in_fire) begin
                wr_idx <= wr_end ? '0 : wr_idx + 1'b1;
                if (wr_end) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= !wr_sel;
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
                    byp[wr_sel]  <= bypass;
`endif
                end
            end
            if (out_fire) begin
                if (rd_end) begin
                    rd_row       <= '0;
                    rd_col       <= '0;
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= !rd_sel;
                end else if (col_first) begin
                    rd_col <= col_end ? '0 : rd_col + 1'b1;
                    if (col_end) rd_row <= rd_row + 1'b1;
                end else begin
                    rd_row <= row_end ? '0 : rd_row + 1'b1;
                    if (row_end) rd_col <= rd_col + 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_matrix_stream_transpose.sv
// tb_matrix_stream_transpose: directed checks for N=2 and N=3 transposers (bypass steps when MATRIX_TRANSPOSE_BYPASS_EN)
module tb_matrix_stream_transpose;
    logic clk, rst;
    logic iv, ir, ov, ordy, ol;
    logic [2:0] id, od;
    logic iv3, ir3, ov3, ordy3, ol3;
    logic [2:0] id3, od3;
    logic bypass;
    int vectors = 0;
    int miscompares = 0;
    logic [23:0] in2  = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [23:0] out2 = {3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd7, 3'd6, 3'd0};
    logic [26:0] in3  = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [26:0] out3 = {3'd1, 3'd4, 3'd7, 3'd2, 3'd5, 3'd0, 3'd3, 3'd6, 3'd1};

    matrix_stream_transpose #(.DW(3), .N(2)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_data(id),
        .out_valid(ov), .out_ready(ordy), .out_data(od),
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
        .bypass(bypass),
`endif
        .out_last(ol)
    );

    matrix_stream_transpose #(.DW(3), .N(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
        .bypass(1'b0),
`endif
        .out_last(ol3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // feed one N=2 matrix with out_ready high, then check its four outputs
    task automatic feed2(input logic [11:0] ins, input logic [11:0] exps, input string tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            iv = 1'b1;
            id = ins[9-3*k +: 3];
            chk({tag, " in_ready"}, ir, 1);
            chk({tag, " early out_valid"}, ov, 0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            iv = 1'b0;
            chk({tag, " out_valid"}, ov, 1);
            chk({tag, " out_data"}, od, exps[9-3*k +: 3]);
            chk({tag, " out_last"}, ol, k == 3);
        end
        @(negedge clk);
        chk({tag, " drained"}, ov, 0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; iv = 1'b0; id = '0; ordy = 1'b1;
        iv3 = 1'b0; id3 = '0; ordy3 = 1'b1; bypass = 1'b0;
        @(negedge clk);
        chk("reset out_valid", ov, 0);
        chk("reset out_last", ol, 0);
        chk("reset in_ready", ir, 1);
        chk("reset out_valid n3", ov3, 0);
        chk("reset in_ready n3", ir3, 1);
        rst = 1'b0;
        // single matrix
        feed2({3'd1, 3'd2, 3'd3, 3'd4}, {3'd1, 3'd3, 3'd2, 3'd4}, "t1");
        // back-to-back matrices, no stalls
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c < 8) begin
                iv = 1'b1;
                id = in2[21-3*c +: 3];
                chk("t2 in_ready", ir, 1);
            end else iv = 1'b0;
            chk("t2 out_valid", ov, (c >= 4 && c < 12));
            if (c >= 4 && c < 12) begin
                chk("t2 out_data", od, out2[21-3*(c-4) +: 3]);
                chk("t2 out_last", ol, (c == 7 || c == 11));
            end
        end
        // backpressure: fill both banks with out_ready low
        ordy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            iv = 1'b1;
            id = in2[21-3*c +: 3];
            chk("t3 fill in_ready", ir, 1);
        end
        @(negedge clk);
        id = 3'd3;
        chk("t3 full in_ready", ir, 0);
        chk("t3 out_valid", ov, 1);
        chk("t3 stall data", od, 1);
        @(negedge clk);
        chk("t3 held in_ready", ir, 0);
        chk("t3 stable data", od, 1);
        chk("t3 stable last", ol, 0);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("t3 one pop data", od, 3);
        chk("t3 one pop in_ready", ir, 0);
        @(negedge clk);
        chk("t3 stall2 data", od, 3);
        chk("t3 stall2 in_ready", ir, 0);
        ordy = 1'b1;
        @(negedge clk);
        chk("t3 drain data2", od, 2);
        chk("t3 drain in_ready2", ir, 0);
        @(negedge clk);
        chk("t3 drain data4", od, 4);
        chk("t3 drain last", ol, 1);
        chk("t3 drain in_ready4", ir, 0);
        @(negedge clk);
        chk("t3 freed in_ready", ir, 1);
        chk("t3 second data5", od, 5);
        chk("t3 second last", ol, 0);
        @(negedge clk);
        iv = 1'b0;
        chk("t3 second data7", od, 7);
        @(negedge clk);
        chk("t3 second data6", od, 6);
        @(negedge clk);
        chk("t3 second data0", od, 0);
        chk("t3 second last0", ol, 1);
        @(negedge clk);
        chk("t3 partial not valid", ov, 0);
        chk("t3 partial in_ready", ir, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // async reset mid-stream with one full bank and one partial
        ordy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            iv = 1'b1;
            id = 3'(c + 1);
        end
        @(negedge clk);
        iv = 1'b0;
        chk("t4 pre-reset valid", ov, 1);
        chk("t4 pre-reset data", od, 1);
        #2 rst = 1'b1;
        #1;
        chk("t4 async out_valid", ov, 0);
        chk("t4 async out_last", ol, 0);
        chk("t4 async in_ready", ir, 1);
        @(negedge clk);
        rst = 1'b0;
        ordy = 1'b1;
        feed2({3'd4, 3'd5, 3'd6, 3'd7}, {3'd4, 3'd6, 3'd5, 3'd7}, "t4");
        // N=3 transpose
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            if (c < 9) begin
                iv3 = 1'b1;
                id3 = in3[24-3*c +: 3];
                chk("t5 in_ready", ir3, 1);
            end else iv3 = 1'b0;
            chk("t5 out_valid", ov3, (c >= 9 && c < 18));
            if (c >= 9 && c < 18) begin
                chk("t5 out_data", od3, out3[24-3*(c-9) +: 3]);
                chk("t5 out_last", ol3, c == 17);
            end
        end
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
        bypass = 1'b1;
        feed2({3'd1, 3'd2, 3'd3, 3'd4}, {3'd1, 3'd2, 3'd3, 3'd4}, "t6 bypass");
        bypass = 1'b0;
        feed2({3'd5, 3'd6, 3'd7, 3'd0}, {3'd5, 3'd7, 3'd6, 3'd0}, "t6 transpose");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/matrix_stream_transpose.md
Name: matrix_stream_transpose

Overview:
- Streaming NxN matrix transposer with ping-pong buffering.
- Accepts matrix elements serially in row-major order on a valid/ready input stream.
- Emits each complete matrix serially in column-major order (its transpose, row-major) on a valid/ready output stream.
- Sits between a serial matrix source and downstream matrix arithmetic blocks; supports one matrix being written while the previous one is read.

Parameters:
- DW, 3, element width in bits.
- N, 2, matrix dimension (N>=2); each matrix is N*N elements.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a valid element.
- in_ready  output  1  block can accept an element this cycle.
- in_data  input  DW  element, row-major order (a11, a12, ..., a1N, a21, ...).
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts the element this cycle.
- out_data  output  DW  element, column-major order of the stored matrix (a11, a21, ..., aN1, a12, ...).
- out_last  output  1  high with the final (N*N-th) element of each output matrix.

Behaviour:
- Storage: two banks (bank 0/1), each N*N x DW, each with a full flag.
- Write side: wr_sel (bank), wr_idx 0..N*N-1.
- Read side: rd_sel (bank), rd_row, rd_col 0..N-1.
- Input handshake:
  - Accept when in_valid && in_ready; element stored at bank[wr_sel][wr_idx], wr_idx increments.
  - in_ready = !full[wr_sel].
  - On acceptance with wr_idx==N*N-1: full[wr_sel] set, wr_idx<=0, wr_sel toggles.
- Output side:
  - out_valid = full[rd_sel].
  - out_data = bank[rd_sel][rd_row*N+rd_col], driven combinationally from registered state; undefined/don't-care when out_valid low.
  - out_last = out_valid && rd_row==N-1 && rd_col==N-1.
- Output transfer (out_valid && out_ready):
  - rd_row increments.
  - At rd_row==N-1: rd_row<=0 and rd_col increments.
  - At the last element: rd_col<=0, full[rd_sel] cleared, rd_sel toggles.
- Latency: out_valid rises the cycle after the N*N-th input element is accepted; first output element is a11.
- Hold: while out_valid && !out_ready, out_data and out_last stay stable.
- Throughput:
  - Sustained 1 element/cycle in and out with both banks in rotation.
  - Input stalls (in_ready low) only when both banks are full.
- Simultaneous events:
  - Last-element output on bank X and input acceptance in the same cycle are independent (different banks).
  - A bank freed on cycle t is writable from cycle t+1.
  - Setting and clearing of the same bank's flag cannot coincide.
- Reset (any time, including mid-matrix):
  - wr_idx, rd_row, rd_col, wr_sel, rd_sel <= 0; both full flags <= 0.
  - out_valid=0, out_last=0, in_ready=1.
  - Partial and buffered matrices are discarded; bank contents need not be cleared.
- Width rules: data passes unmodified (no arithmetic); index counters sized $clog2(N*N) and $clog2(N), never exceed N*N-1 / N-1.

Optional Feature:
- Macro: MATRIX_TRANSPOSE_BYPASS_EN.
- When defined: extra input port bypass (1 bit).
  - Sampled once per output matrix: registered into the bank alongside its full flag at the cycle the matrix completes on the input side.
  - bypass=1 on that cycle: the matrix is output in row-major order (rd_col increments first), i.e. passes through untransposed.
  - out_last timing and handshakes unchanged.
- When undefined: port absent; every matrix is transposed.

Test Plan:
- N=2, DW=3, out_ready=1: input 1,2,3,4 -> output 1,3,2,4; out_last only with 4; out_valid first high the cycle after 4 accepted.
- N=2 back-to-back, continuous in_valid and out_ready: inputs 1,2,3,4,5,6,7,0 -> output 1,3,2,4,5,7,6,0 with no input stalls; out_last on 4 and 0.
- Backpressure, out_ready=0: feed 8 elements -> in_ready low after 8th acceptance; 9th element held. Raise out_ready for one element -> in_ready stays low until the first matrix fully drains, then high the next cycle. out_data stable while stalled.
- Reset mid-stream: accept 1,2,3, assert rst -> out_valid=0, in_ready=1 immediately. Then feed 4,5,6,7 -> output 4,6,5,7.
- Parameter N=3: input 1..7,0,1 -> output 1,4,7,2,5,0,3,6,1; out_last on final 1.
- With MATRIX_TRANSPOSE_BYPASS_EN and bypass=1 at completion: input 1,2,3,4 -> output 1,2,3,4. Next matrix with bypass=0 -> transposed.
